program_loader_ctrl: RTL and testbench

Boot-time sequencer for the multicycle stack CPU. It holds the CPU in reset by driving the control-unit and register resets. It accepts a byte stream from the host link, assembles big-endian 16-bit words, and writes them into program memory through one memory write port. It then releases the CPU after a fixed reset-hold interval. It sits beside the full-integration top and owns the memory write path whenever CpuRst is high.

---
 rtl/program_loader_ctrl_if.sv | 29 ++
 rtl/program_loader_ctrl.sv | 129 ++++++++++++
 tb/tb_program_loader_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_ctrl_if.sv
// Byte-stream intake and program-memory write port of the boot loader.
// The loader sits on the slave side: it consumes host bytes and produces
// memory writes; the host/memory side uses the master modport.
interface program_loader_ctrl_if;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic [15:0] MemAddr;
    logic [15:0] MemDataOut;
    logic        MemWrite;

    modport master (
        output ByteIn,
        output ByteValid,
        input  ByteReady,
        input  MemAddr,
        input  MemDataOut,
        input  MemWrite
    );

    modport slave (
        input  ByteIn,
        input  ByteValid,
        output ByteReady,
        output MemAddr,
        output MemDataOut,
        output MemWrite
    );
endinterface

// File: rtl/program_loader_ctrl.sv
// Boot-time sequencer for the multicycle stack CPU. Holds the CPU in reset,
// assembles big-endian 16-bit words from the host byte stream, writes them to
// program memory, then releases the CPU after a fixed hold interval.
module program_loader_ctrl #(
    parameter logic [15:0] LOAD_BASE  = 16'h0000,
    parameter int          MAX_WORDS  = 1024,
    parameter int          RESET_HOLD = 4
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [15:0]           WordCount,
    program_loader_ctrl_if.slave  bus,
    output logic                  CpuRst,
    output logic                  Done,
    output logic                  Error,
    output logic [15:0]           LoadedCount,
    output logic [2:0]            State
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_HI = 3'd1,
        LOAD_LO = 3'd2,
        WRITE   = 3'd3,
        RELEASE = 3'd4,
        RUN     = 3'd5,
        ERR     = 3'd6
    } state_t;

    // Hold counter only needs to reach RESET_HOLD-1.
    localparam int          HOLD_W      = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    // One extra bit so a WordCount of 16'hFFFF compares correctly.
    localparam logic [16:0] MAX_WORDS_W = 17'(MAX_WORDS);

    state_t              stateReg;
    logic [15:0]         wordCountReg;
    logic [15:0]         loadedCountReg;
    logic [15:0]         dataReg;
    logic [HOLD_W-1:0]   holdCountReg;
    logic                cpuRstReg;
    logic                doneReg;
    logic                errorReg;

    logic                startAccept;
    logic [15:0]         loadedInc;

    // Start is only honoured while no load/release is in progress.
    assign startAccept = Start && ((stateReg == IDLE) || (stateReg == RUN) || (stateReg == ERR));
    assign loadedInc   = loadedCountReg + 16'd1;

    // Main sequencer: state, word assembly, counters and registered status flags.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            stateReg       <= IDLE;
            wordCountReg   <= '0;
            loadedCountReg <= '0;
            dataReg        <= '0;
            holdCountReg   <= '0;
            cpuRstReg      <= 1'b1;
            doneReg        <= 1'b0;
            errorReg       <= 1'b0;
        end else if (startAccept) begin
            wordCountReg   <= WordCount;
            loadedCountReg <= '0;
            holdCountReg   <= '0;
            cpuRstReg      <= 1'b1;
            doneReg        <= 1'b0;
            errorReg       <= 1'b0;
            if (WordCount == 16'd0) begin
                stateReg <= RELEASE;
            end else if ({1'b0, WordCount} > MAX_WORDS_W) begin
                stateReg <= ERR;
                errorReg <= 1'b1;
            end else begin
                stateReg <= LOAD_HI;
            end
        end else begin
            case (stateReg)
                // ByteReady is high in both load states, so ByteValid alone marks a transfer.
                LOAD_HI: begin
                    if (bus.ByteValid) begin
                        dataReg[15:8] <= bus.ByteIn;
                        stateReg      <= LOAD_LO;
                    end
                end
                LOAD_LO: begin
                    if (bus.ByteValid) begin
                        dataReg[7:0] <= bus.ByteIn;
                        stateReg     <= WRITE;
                    end
                end
                WRITE: begin
                    loadedCountReg <= loadedInc;
                    if (loadedInc == wordCountReg) begin
                        stateReg     <= RELEASE;
                        holdCountReg <= '0;
                    end else begin
                        stateReg <= LOAD_HI;
                    end
                end
                RELEASE: begin
                    if (holdCountReg == HOLD_LAST) begin
                        stateReg  <= RUN;
                        cpuRstReg <= 1'b0;
                        doneReg   <= 1'b1;
                    end else begin
                        holdCountReg <= holdCountReg + HOLD_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs come only from registers; bus strobes are decoded from the state.
    assign bus.ByteReady  = (stateReg == LOAD_HI) || (stateReg == LOAD_LO);
    assign bus.MemWrite   = (stateReg == WRITE);
    assign bus.MemAddr    = LOAD_BASE + loadedCountReg;
    assign bus.MemDataOut = dataReg;
    assign CpuRst         = cpuRstReg;
    assign Done           = doneReg;
    assign Error          = errorReg;
    assign LoadedCount    = loadedCountReg;
    assign State          = stateReg;

endmodule

// File: tb/tb_program_loader_ctrl.sv
// Directed bench for program_loader_ctrl: per-cycle vector table for the two
// basic loads, then hand-written sequences for error, reset and reload cases.
module tb_program_loader_ctrl;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic [15:0] WordCount;
    logic        CpuRst;
    logic        Done;
    logic        Error;
    logic [15:0] LoadedCount;
    logic [2:0]  State;

    program_loader_ctrl_if busIf ();

    program_loader_ctrl dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Start       (Start),
        .WordCount   (WordCount),
        .bus         (busIf.slave),
        .CpuRst      (CpuRst),
        .Done        (Done),
        .Error       (Error),
        .LoadedCount (LoadedCount),
        .State       (State)
    );

    always #5 CLK = ~CLK;

    // Small program-memory model and write counter.
    logic [15:0] mem [0:15];
    int          writeCount = 0;

    always @(posedge CLK) begin
        if (busIf.MemWrite) begin
            mem[busIf.MemAddr[3:0]] <= busIf.MemDataOut;
            writeCount              <= writeCount + 1;
        end
    end

    typedef struct {
        logic        rst;
        logic        start;
        logic [15:0] wc;
        logic        bv;
        logic [7:0]  bi;
        logic [2:0]  st;
        logic        br;
        logic        mw;
        logic [15:0] addr;
        logic [15:0] data;
        logic        cpu;
        logic        done;
        logic        err;
        logic [15:0] lc;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic r, input logic s, input logic [15:0] w,
                                input logic v, input logic [7:0] b,
                                input logic [2:0] st, input logic br, input logic mw,
                                input logic [15:0] addr, input logic [15:0] data,
                                input logic cpu, input logic done, input logic err,
                                input logic [15:0] lc);
        vec_t t;
        t.rst = r; t.start = s; t.wc = w; t.bv = v; t.bi = b;
        t.st = st; t.br = br; t.mw = mw; t.addr = addr; t.data = data;
        t.cpu = cpu; t.done = done; t.err = err; t.lc = lc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic r, input logic s, input logic [15:0] w,
                        input logic v, input logic [7:0] b);
        @(negedge CLK);
        Reset           = r;
        Start           = s;
        WordCount       = w;
        busIf.ByteValid = v;
        busIf.ByteIn    = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic expectSt(input string tag, input logic [2:0] st, input logic cpu,
                            input logic done, input logic err, input logic [15:0] lc);
        chk({tag, ".state"}, 32'(State), 32'(st));
        chk({tag, ".cpuRst"}, 32'(CpuRst), 32'(cpu));
        chk({tag, ".done"}, 32'(Done), 32'(done));
        chk({tag, ".error"}, 32'(Error), 32'(err));
        chk({tag, ".loaded"}, 32'(LoadedCount), 32'(lc));
    endtask

    task automatic expectWr(input string tag, input logic [15:0] addr, input logic [15:0] data);
        chk({tag, ".memWrite"}, 32'(busIf.MemWrite), 32'd1);
        chk({tag, ".memAddr"}, 32'(busIf.MemAddr), 32'(addr));
        chk({tag, ".memData"}, 32'(busIf.MemDataOut), 32'(data));
    endtask

    int wrBase;

    initial begin
        Reset = 1'b1; Start = 1'b0; WordCount = '0;
        busIf.ByteValid = 1'b0; busIf.ByteIn = '0;

        // ---- table: reset, continuous load of 2 words, stalled reload from RUN ----
        vecs.push_back(mk(1,0,0,0,8'h00, 0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,0,0,0,8'h00, 0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(0,1,2,0,8'h00, 1,1,0,0,0, 1,0,0,0));
        vecs.push_back(mk(0,0,0,1,8'h12, 2,1,0,0,0, 1,0,0,0));
        vecs.push_back(mk(0,0,0,1,8'h34, 3,0,1,16'h0000,16'h1234, 1,0,0,0));
        vecs.push_back(mk(0,0,0,1,8'h56, 1,1,0,0,0, 1,0,0,1));   // 56 held, not taken in WRITE
        vecs.push_back(mk(0,0,0,1,8'h56, 2,1,0,0,0, 1,0,0,1));
        vecs.push_back(mk(0,0,0,1,8'h78, 3,0,1,16'h0001,16'h5678, 1,0,0,1));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0,0,0,0,8'h00, 4,0,0,0,0, 1,0,0,2));
        vecs.push_back(mk(0,0,0,0,8'h00, 5,0,0,0,0, 0,1,0,2));
        vecs.push_back(mk(0,0,0,0,8'h00, 5,0,0,0,0, 0,1,0,2));
        vecs.push_back(mk(0,1,2,0,8'h00, 1,1,0,0,0, 1,0,0,0));
        vecs.push_back(mk(0,0,0,1,8'h12, 2,1,0,0,0, 1,0,0,0));
        vecs.push_back(mk(0,0,0,1,8'h34, 3,0,1,16'h0000,16'h1234, 1,0,0,0));
        for (int k = 0; k < 5; k++)                              // five idle cycles
            vecs.push_back(mk(0,0,0,0,8'h00, 1,1,0,0,0, 1,0,0,1));
        vecs.push_back(mk(0,0,0,1,8'h56, 2,1,0,0,0, 1,0,0,1));
        vecs.push_back(mk(0,0,0,1,8'h78, 3,0,1,16'h0001,16'h5678, 1,0,0,1));
        vecs.push_back(mk(0,0,0,0,8'h00, 4,0,0,0,0, 1,0,0,2));
        vecs.push_back(mk(0,1,7,0,8'h00, 4,0,0,0,0, 1,0,0,2));   // Start ignored in RELEASE
        vecs.push_back(mk(0,0,0,0,8'h00, 4,0,0,0,0, 1,0,0,2));
        vecs.push_back(mk(0,0,0,0,8'h00, 4,0,0,0,0, 1,0,0,2));
        vecs.push_back(mk(0,0,0,0,8'h00, 5,0,0,0,0, 0,1,0,2));

        wrBase = writeCount;
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            step(vecs[i].rst, vecs[i].start, vecs[i].wc, vecs[i].bv, vecs[i].bi);
            expectSt(tag, vecs[i].st, vecs[i].cpu, vecs[i].done, vecs[i].err, vecs[i].lc);
            chk({tag, ".byteReady"}, 32'(busIf.ByteReady), 32'(vecs[i].br));
            chk({tag, ".memWrite"}, 32'(busIf.MemWrite), 32'(vecs[i].mw));
            if (vecs[i].mw) begin
                chk({tag, ".memAddr"}, 32'(busIf.MemAddr), 32'(vecs[i].addr));
                chk({tag, ".memData"}, 32'(busIf.MemDataOut), 32'(vecs[i].data));
            end
            $display("vec %0d state=%0d cpuRst=%0b done=%0b memWrite=%0b loaded=%0d",
                     i, State, CpuRst, Done, busIf.MemWrite, LoadedCount);
        end
        chk("table.writes", 32'(writeCount - wrBase), 32'd4);
        chk("table.mem0", 32'(mem[0]), 32'h1234);
        chk("table.mem1", 32'(mem[1]), 32'h5678);

        // ---- oversize WordCount, then zero-length load out of ERR ----
        step(1,0,0,0,8'h00);
        wrBase = writeCount;
        step(0,1,16'd1025,0,8'h00);
        expectSt("err.enter", 6, 1, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step(0,0,0,1,8'hEE);
            expectSt("err.hold", 6, 1, 0, 1, 0);
            chk("err.byteReady", 32'(busIf.ByteReady), 32'd0);
        end
        chk("err.noWrites", 32'(writeCount - wrBase), 32'd0);
        step(0,1,16'd0,0,8'h00);
        expectSt("zero.release", 4, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0,0,0,0,8'h00);
            expectSt("zero.hold", 4, 1, 0, 0, 0);
        end
        step(0,0,0,0,8'h00);
        expectSt("zero.run", 5, 0, 1, 0, 0);
        $display("seq err/zero state=%0d error=%0b done=%0b", State, Error, Done);

        // ---- reset in LOAD_LO of second word ----
        wrBase = writeCount;
        step(0,1,16'd3,0,8'h00);
        expectSt("rst.start", 1, 1, 0, 0, 0);
        step(0,0,0,1,8'h11);
        step(0,0,0,1,8'h22);
        expectWr("rst.w0", 16'h0000, 16'h1122);
        step(0,0,0,0,8'h00);
        step(0,0,0,1,8'h33);
        expectSt("rst.lo", 2, 1, 0, 0, 1);
        step(1,0,0,1,8'h44);
        expectSt("rst.idle", 0, 1, 0, 0, 0);
        chk("rst.memWrite", 32'(busIf.MemWrite), 32'd0);
        chk("rst.mem0", 32'(mem[0]), 32'h1122);
        chk("rst.writes", 32'(writeCount - wrBase), 32'd1);
        $display("seq reset-mid-load state=%0d mem0=%h", State, mem[0]);

        // ---- MAX_WORDS is legal; Start ignored in LOAD_HI ----
        step(0,1,16'd1024,0,8'h00);
        expectSt("max.start", 1, 1, 0, 0, 0);
        step(0,1,16'd1025,0,8'h00);
        expectSt("max.ignore", 1, 1, 0, 0, 0);
        step(1,0,0,0,8'h00);
        $display("seq max-words state=%0d", State);

        // ---- reach RUN, then reload one word from RUN ----
        step(0,1,16'd0,0,8'h00);
        for (int k = 0; k < 4; k++) step(0,0,0,0,8'h00);
        expectSt("reload.run", 5, 0, 1, 0, 0);
        step(0,1,16'd1,0,8'h00);
        expectSt("reload.start", 1, 1, 0, 0, 0);
        step(0,0,0,1,8'hAB);
        step(0,0,0,1,8'hCD);
        expectWr("reload.w0", 16'h0000, 16'hABCD);
        step(0,0,0,0,8'h00);
        expectSt("reload.release", 4, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(0,0,0,0,8'h00);
        expectSt("reload.hold", 4, 1, 0, 0, 1);
        step(0,0,0,0,8'h00);
        expectSt("reload.done", 5, 0, 1, 0, 1);
        chk("reload.mem0", 32'(mem[0]), 32'hABCD);
        $display("seq reload state=%0d mem0=%h done=%0b", State, mem[0], Done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
